bht_update_ctrl: RTL and testbench

BHT_UPDATE_CTRL -- requirements
Module: bht_update_ctrl

---
 rtl/bht_update_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_bht_update_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_update_ctrl.sv
// Arbitrates a single-port, 1-cycle-read BHT between fetch lookups and
// queued read-modify-write counter updates from execute.
// Ports:
//   clk, rst                         clock, async active-low reset
//   lookup_valid/idx, lookup_ready   fetch prediction request / grant
//   predict_valid/taken              prediction, one cycle after a granted lookup
//   upd_valid/idx/taken, upd_ready   branch resolution into the update queue
//   bht_en/we/addr/wdata, bht_rdata  BHT SRAM port
//   init_done, busy                  table initialised / update work pending
module bht_update_ctrl #(
    parameter int unsigned INDEX_BITS   = 6,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lookup_valid,
    input  logic [INDEX_BITS-1:0] lookup_idx,
    output logic                  lookup_ready,
    output logic                  predict_valid,
    output logic                  predict_taken,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_idx,
    input  logic                  upd_taken,
    output logic                  upd_ready,
    output logic                  bht_en,
    output logic                  bht_we,
    output logic [INDEX_BITS-1:0] bht_addr,
    output logic [1:0]            bht_wdata,
    input  logic [1:0]            bht_rdata,
    output logic                  init_done,
    output logic                  busy
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ST_W  = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned LAST_IDX = (1 << INDEX_BITS) - 1;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_RD_WAIT, S_WR} state_t;

    typedef struct packed {
        logic [INDEX_BITS-1:0] idx;
        logic                  taken;
    } upd_t;

    state_t                r_state;
    logic                  r_run;
    logic [INDEX_BITS-1:0] r_init_idx;
    logic                  r_init_done;
    upd_t                  r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [ST_W-1:0]       r_starve;
    logic [1:0]            r_ctr;
    logic                  r_pred_valid;

    logic w_full, w_empty, w_preempt, w_fetch, w_push, w_pop;
    logic w_rd_go, w_wr_go, w_init_wr;
    upd_t w_head;
    logic [1:0] w_sat;

    // 2-bit saturating counter step
    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? c : c + 2'b01;
        else   return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_head    = r_fifo[r_rd_ptr];
    assign w_sat     = sat(r_ctr, w_head.taken);
    // An update that has been blocked long enough takes the port from fetch
    assign w_preempt = ((r_state == S_RD) || (r_state == S_WR)) &&
                       (r_starve >= ST_W'(STARVE_LIMIT));
    assign w_fetch   = lookup_valid && lookup_ready;
    assign w_push    = upd_valid && upd_ready;
    assign w_rd_go   = (r_state == S_RD) && !w_fetch;
    assign w_wr_go   = (r_state == S_WR) && !w_fetch;
    assign w_pop     = w_wr_go;
    // r_run holds off the first table write until reset has been released
    assign w_init_wr = (r_state == S_INIT) && r_run;

    assign lookup_ready  = r_init_done && !w_preempt;
    assign upd_ready     = r_init_done && !w_full;
    assign predict_valid = r_pred_valid;
    assign predict_taken = r_pred_valid & bht_rdata[1];
    assign init_done     = r_init_done;
    assign busy          = !w_empty || (r_state == S_RD) ||
                           (r_state == S_RD_WAIT) || (r_state == S_WR);

    // BHT port mux; fetch has priority except during init or preempt
    always_comb begin
        bht_en    = 1'b0;
        bht_we    = 1'b0;
        bht_addr  = '0;
        bht_wdata = '0;
        if (w_init_wr) begin
            bht_en    = 1'b1;
            bht_we    = 1'b1;
            bht_addr  = r_init_idx;
            bht_wdata = 2'b01;
        end else if (w_fetch) begin
            bht_en   = 1'b1;
            bht_addr = lookup_idx;
        end else if (w_rd_go) begin
            bht_en   = 1'b1;
            bht_addr = w_head.idx;
        end else if (w_wr_go) begin
            bht_en    = 1'b1;
            bht_we    = 1'b1;
            bht_addr  = w_head.idx;
            bht_wdata = w_sat;
        end
    end

    // Queue payload storage; validity is tracked by pointers/count
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= '{idx: upd_idx, taken: upd_taken};
    end

    // Control FSM, queue pointers and starvation counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_INIT;
            r_run        <= 1'b0;
            r_init_idx   <= '0;
            r_init_done  <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_starve     <= '0;
            r_ctr        <= '0;
            r_pred_valid <= 1'b0;
        end else begin
            r_run        <= 1'b1;
            r_pred_valid <= w_fetch;

            if (w_push)
                r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_INIT: begin
                    if (r_run) begin
                        r_init_idx <= r_init_idx + INDEX_BITS'(1);
                        if (r_init_idx == INDEX_BITS'(LAST_IDX)) begin
                            r_state     <= S_IDLE;
                            r_init_done <= 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    if (!w_empty) r_state <= S_RD;
                end
                S_RD: begin
                    if (w_rd_go) begin
                        r_state  <= S_RD_WAIT;
                        r_starve <= '0;
                    end else begin
                        r_starve <= r_starve + ST_W'(1);
                    end
                end
                S_RD_WAIT: begin
                    r_ctr   <= bht_rdata;
                    r_state <= S_WR;
                end
                S_WR: begin
                    if (w_wr_go) begin
                        r_state  <= S_IDLE;
                        r_starve <= '0;
                    end else begin
                        r_starve <= r_starve + ST_W'(1);
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_bht_update_ctrl.sv
// Scoreboarded bench for bht_update_ctrl with a behavioural 1-cycle BHT SRAM.
module tb_bht_update_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       lookup_valid;
    logic [5:0] lookup_idx;
    logic       lookup_ready;
    logic       predict_valid;
    logic       predict_taken;
    logic       upd_valid;
    logic [5:0] upd_idx;
    logic       upd_taken;
    logic       upd_ready;
    logic       bht_en;
    logic       bht_we;
    logic [5:0] bht_addr;
    logic [1:0] bht_wdata;
    logic [1:0] bht_rdata;
    logic       init_done;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic       pq[$];
    logic [7:0] wq[$];
    logic       lk_exp;
    logic [7:0] exp_w;
    logic       track_upd;
    logic       last_rdy;
    logic       last_urdy;
    logic [1:0] mem [64];

    bht_update_ctrl dut (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_idx(lookup_idx), .lookup_ready(lookup_ready),
        .predict_valid(predict_valid), .predict_taken(predict_taken),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_ready(upd_ready),
        .bht_en(bht_en), .bht_we(bht_we), .bht_addr(bht_addr), .bht_wdata(bht_wdata),
        .bht_rdata(bht_rdata), .init_done(init_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-port synchronous-read BHT
    always @(posedge clk) begin
        if (bht_en) begin
            if (bht_we) mem[bht_addr] <= bht_wdata;
            else        bht_rdata <= mem[bht_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: predictions and post-init writes checked against the queues
    always @(negedge clk) begin
        if (predict_valid) begin
            if (pq.size() == 0) chk("pred_unexpected", 32'd1, 32'd0);
            else chk("predict_taken", 32'(predict_taken), 32'(pq.pop_front()));
        end
        if (bht_en && bht_we && init_done) begin
            if (wq.size() == 0) chk("write_unexpected", 32'({bht_addr, bht_wdata}), 32'hFFFF);
            else chk("write_addr_data", 32'({bht_addr, bht_wdata}), 32'(wq.pop_front()));
        end
    end

    // One cycle: record accepted transactions at negedge, return at posedge+1
    task automatic tick();
        @(negedge clk);
        if (lookup_valid && lookup_ready) pq.push_back(lk_exp);
        if (upd_valid && upd_ready && track_upd) wq.push_back(exp_w);
        last_rdy  = lookup_ready;
        last_urdy = upd_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic check_init();
        int bad = 0;
        int gbad = 0;
        int waited = 0;
        @(negedge clk);
        while (!bht_en && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        chk("init_start", 32'(bht_en), 32'd1);
        chk("init_first_addr", 32'(bht_addr), 32'd0);
        for (int i = 0; i < 64; i++) begin
            if (!(bht_en && bht_we && bht_addr == 6'(i) && bht_wdata == 2'b01)) bad++;
            if (lookup_ready || upd_ready || init_done) gbad++;
            @(negedge clk);
        end
        chk("init_writes_bad", 32'(bad), 32'd0);
        chk("init_grants_bad", 32'(gbad), 32'd0);
        chk("init_done_after", 32'(init_done), 32'd1);
        chk("init_no_extra_write", 32'(bht_we), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_lookup(input logic [5:0] idx, input logic exp);
        int n = 0;
        lookup_valid = 1'b1;
        lookup_idx   = idx;
        lk_exp       = exp;
        tick();
        while (!last_rdy && n < 50) begin
            tick();
            n++;
        end
        chk("lookup_granted", 32'(last_rdy), 32'd1);
        lookup_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_update(input logic [5:0] idx, input logic tk, input logic [1:0] wd);
        int n = 0;
        upd_valid = 1'b1;
        upd_idx   = idx;
        upd_taken = tk;
        exp_w     = {idx, wd};
        tick();
        while (!last_urdy && n < 200) begin
            tick();
            n++;
        end
        chk("update_accepted", 32'(last_urdy), 32'd1);
        upd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        chk("wait_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int lows;
        int low_at [2];
        rst = 1'b0;
        lookup_valid = 1'b0; lookup_idx = '0;
        upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0;
        lk_exp = 1'b0; exp_w = '0; track_upd = 1'b1;
        last_rdy = 1'b0; last_urdy = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_lookup_ready", 32'(lookup_ready), 32'd0);
        chk("rst_upd_ready", 32'(upd_ready), 32'd0);
        chk("rst_bht_en", 32'(bht_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_predict_valid", 32'(predict_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        check_init();

        // Basic lookup then two taken updates: 01 -> 10 -> 11
        do_lookup(6'd5, 1'b0);
        do_update(6'd5, 1'b1, 2'b10);
        do_update(6'd5, 1'b1, 2'b11);
        wait_idle();
        do_lookup(6'd5, 1'b1);

        // Saturation at 3 (taken) and at 0 (not taken)
        do_update(6'd5, 1'b1, 2'b11);
        do_update(6'd7, 1'b0, 2'b00);
        do_update(6'd7, 1'b0, 2'b00);
        wait_idle();
        do_lookup(6'd7, 1'b0);
        do_lookup(6'd5, 1'b1);

        // Starvation: continuous lookups of idx 9 with one queued update 01 -> 10
        lookup_valid = 1'b1; lookup_idx = 6'd9; lk_exp = 1'b0;
        upd_valid = 1'b1; upd_idx = 6'd9; upd_taken = 1'b1; exp_w = {6'd9, 2'b10};
        tick();
        chk("starve_push", 32'(last_urdy), 32'd1);
        upd_valid = 1'b0;
        lows = 0; low_at[0] = 0; low_at[1] = 0;
        for (int i = 1; i < 30; i++) begin
            lk_exp = (lows >= 2);
            tick();
            if (!last_rdy) begin
                if (lows < 2) low_at[lows] = i;
                lows++;
            end
        end
        lookup_valid = 1'b0;
        chk("starve_low_count", 32'(lows), 32'd2);
        chk("starve_read_preempt_cycle", 32'(low_at[0]), 32'd10);
        chk("starve_write_preempt_cycle", 32'(low_at[1]), 32'd20);
        chk("starve_done_busy", 32'(busy), 32'd0);
        tick();

        // Queue full under continuous lookups; fifth offer held until space
        lookup_valid = 1'b1; lookup_idx = 6'd30; lk_exp = 1'b0;
        for (int k = 0; k < 4; k++) begin
            upd_valid = 1'b1; upd_idx = 6'(20 + k); upd_taken = 1'b1;
            exp_w = {6'(20 + k), 2'b10};
            tick();
            chk("fill_accept", 32'(last_urdy), 32'd1);
        end
        upd_idx = 6'd24; upd_taken = 1'b0; exp_w = {6'd24, 2'b00};
        tick();
        chk("full_refuse", 32'(last_urdy), 32'd0);
        tick();
        chk("full_refuse_hold", 32'(last_urdy), 32'd0);
        begin
            int n = 0;
            while (!last_urdy && n < 200) begin
                tick();
                n++;
            end
        end
        chk("fifth_eventually_accepted", 32'(last_urdy), 32'd1);
        upd_valid = 1'b0;
        lookup_valid = 1'b0;
        wait_idle();
        do_lookup(6'd23, 1'b1);
        do_lookup(6'd24, 1'b0);

        // Reset while an update is blocked in WR: the write must never appear
        track_upd = 1'b0;
        lookup_valid = 1'b1; lookup_idx = 6'd41; lk_exp = 1'b0;
        upd_valid = 1'b1; upd_idx = 6'd40; upd_taken = 1'b1;
        tick();
        upd_valid = 1'b0;
        repeat (14) tick();
        rst = 1'b0;
        lookup_valid = 1'b0;
        track_upd = 1'b1;
        @(negedge clk);
        chk("rst_wr_busy", 32'(busy), 32'd0);
        chk("rst_wr_bht_en", 32'(bht_en), 32'd0);
        chk("rst_wr_init_done", 32'(init_done), 32'd0);
        chk("rst_wr_predict_valid", 32'(predict_valid), 32'd0);
        pq.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        check_init();
        do_lookup(6'd40, 1'b0);
        do_lookup(6'd5, 1'b0);

        chk("pred_queue_empty", 32'(pq.size()), 32'd0);
        chk("write_queue_empty", 32'(wq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
